// File: rtl/wb_gpio_ctrl.sv
// Wishbone GPIO controller: output register, synchronised inputs, edge-latched level interrupt.
// Optional per-channel input debouncer is compiled in when GPIO_DEBOUNCE_EN is defined.
module wb_gpio_ctrl #(
  parameter int               IN_W            = 4,
  parameter int               OUT_W           = 4,
  parameter logic [OUT_W-1:0] OUT_RST         = '0,
  parameter int               DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [2:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [IN_W-1:0]  gpio_i,
  output logic [OUT_W-1:0] gpio_o,
  output logic             irq_o
);

  if (IN_W < 1 || IN_W > 32 || OUT_W < 1 || OUT_W > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("wb_gpio_ctrl: parameter out of range");
  end

  localparam logic [2:0] ADR_DOUT = 3'd0;
  localparam logic [2:0] ADR_DIN  = 3'd1;
  localparam logic [2:0] ADR_EN   = 3'd2;
  localparam logic [2:0] ADR_POL  = 3'd3;
  localparam logic [2:0] ADR_STAT = 3'd4;

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic [IN_W-1:0]  en_q, en_d;
  logic [IN_W-1:0]  pol_q, pol_d;
  logic [IN_W-1:0]  stat_q, stat_d;
  logic [IN_W-1:0]  sync1_q, sync2_q;
  logic [IN_W-1:0]  filt_dly_q;
  logic [IN_W-1:0]  filt;
  logic [IN_W-1:0]  edge_hit;
  logic             access;
  logic             wr;
  logic [31:0]      wmask;
  logic [31:0]      rdata;

`ifdef GPIO_DEBOUNCE_EN
  localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IN_W-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]            filt_q, filt_d;

  // Filtered bit only follows sync after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    for (int k = 0; k < IN_W; k++) begin
      if (sync2_q[k] == filt_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_TC) begin
        filt_d[k] = sync2_q[k];
        cnt_d[k]  = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  always_comb begin
    access = wb_cyc_i & wb_stb_i & ~ack_q;
    wr     = access & wb_we_i;
    wmask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    case (wb_adr_i)
      ADR_DOUT: rdata = 32'(dout_q);
      ADR_DIN:  rdata = 32'(filt);
      ADR_EN:   rdata = 32'(en_q);
      ADR_POL:  rdata = 32'(pol_q);
      ADR_STAT: rdata = 32'(stat_q);
      default:  rdata = '0;
    endcase

    ack_d = access;
    dat_d = access ? rdata : dat_q;

    dout_d = dout_q;
    en_d   = en_q;
    pol_d  = pol_q;
    stat_d = stat_q;
    if (wr) begin
      case (wb_adr_i)
        ADR_DOUT: dout_d = OUT_W'((32'(dout_q) & ~wmask) | (wb_dat_i & wmask));
        ADR_EN:   en_d   = IN_W'((32'(en_q) & ~wmask) | (wb_dat_i & wmask));
        ADR_POL:  pol_d  = IN_W'((32'(pol_q) & ~wmask) | (wb_dat_i & wmask));
        ADR_STAT: stat_d = stat_q & ~IN_W'(wb_dat_i & wmask);
        default:  ;
      endcase
    end

    // New edges are OR-ed in after the W1C so a same-cycle set beats a clear.
    edge_hit = (filt ^ filt_dly_q) & ~(filt ^ pol_q);
    stat_d   = stat_d | edge_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      dout_q     <= OUT_RST;
      en_q       <= '0;
      pol_q      <= '0;
      stat_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_dly_q <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      dout_q     <= dout_d;
      en_q       <= en_d;
      pol_q      <= pol_d;
      stat_q     <= stat_d;
      sync1_q    <= gpio_i;
      sync2_q    <= sync1_q;
      filt_dly_q <= filt;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign gpio_o   = dout_q;
  assign irq_o    = |(stat_q & en_q);

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Directed bench for wb_gpio_ctrl; read data is checked against a queue of expected values.
// Debounce expectations switch on GPIO_DEBOUNCE_EN with DEBOUNCE_CYCLES=8.
module tb_wb_gpio_ctrl;
  localparam int DC = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
  localparam logic [31:0] GLITCH_STAT = 32'h0;
`else
  localparam int LAT = 2;
  localparam logic [31:0] GLITCH_STAT = 32'h1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [2:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [3:0]  gpio_i;
  logic [3:0]  gpio_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  wb_gpio_ctrl #(
    .IN_W(4), .OUT_W(4), .OUT_RST(4'h5), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the bus idle for a cycle.
  task automatic bus(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel);
    logic [31:0] e;
    string       t;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    @(posedge clk); #1;
    chk("ack_after_access", 32'(wb_ack_o), 32'h1);
    if (!we) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, wb_dat_o, e);
    end
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    chk("ack_single_cycle", 32'(wb_ack_o), 32'h0);
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] adr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus(1'b0, adr, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus(1'b1, adr, dat, sel);
  endtask

  initial begin
    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    gpio_i = 4'h0;

    // reset state
    #98;
    chk("rst_gpio_o", 32'(gpio_o), 32'h5);
    chk("rst_ack", 32'(wb_ack_o), 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(3'd0, 32'h5, "rst_dout");
    rd(3'd1, 32'h0, "rst_din");
    rd(3'd2, 32'h0, "rst_en");
    rd(3'd3, 32'h0, "rst_pol");
    rd(3'd4, 32'h0, "rst_stat");

    // DOUT writes with byte selects
    wr(3'd0, 32'h0000_000F, 4'h1);
    chk("dout_write_gpio", 32'(gpio_o), 32'hF);
    rd(3'd0, 32'hF, "dout_readback");
    wr(3'd0, 32'h0000_0000, 4'h2);
    chk("dout_sel_masked", 32'(gpio_o), 32'hF);
    wr(3'd0, 32'hFFFF_FFA5, 4'hF);
    chk("dout_full_write", 32'(gpio_o), 32'h5);
    rd(3'd0, 32'h5, "dout_upper_zero");
    wr(3'd0, 32'h0000_000C, 4'h1);

    // held strobe acks every second cycle
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("held_strobe_ack", 32'(wb_ack_o), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);

    // rising edge on bit1, exact input latency observed through irq
    wr(3'd3, 32'h2, 4'hF);
    wr(3'd2, 32'h2, 4'hF);
    chk("irq_idle", 32'(irq_o), 32'h0);
    gpio_i = 4'hA;
    repeat (LAT) @(negedge clk);
    chk("stat_not_early", 32'(irq_o), 32'h0);
    @(negedge clk);
    chk("stat_set_latency", 32'(irq_o), 32'h1);
    rd(3'd1, 32'hA, "din_after_change");
    rd(3'd4, 32'h2, "stat_rise");
    wr(3'd4, 32'h2, 4'hF);
    chk("irq_after_w1c", 32'(irq_o), 32'h0);
    rd(3'd4, 32'h0, "stat_w1c");

    // falling edge on a rising-polarity channel does not set
    gpio_i = 4'h8;
    repeat (LAT + 3) @(negedge clk);
    chk("irq_no_fall", 32'(irq_o), 32'h0);
    rd(3'd4, 32'h0, "stat_no_fall");
    rd(3'd1, 32'h8, "din_8");

    // falling edge on bit3 (POL=0) sets regardless of enable
    gpio_i = 4'h0;
    repeat (LAT + 3) @(negedge clk);
    rd(3'd4, 32'h8, "stat_fall_masked");
    chk("irq_masked", 32'(irq_o), 32'h0);
    wr(3'd4, 32'h0, 4'hF);
    rd(3'd4, 32'h8, "w1c_zero_no_effect");
    wr(3'd2, 32'hA, 4'hF);
    chk("irq_on_enable", 32'(irq_o), 32'h1);
    wr(3'd4, 32'h8, 4'hF);
    chk("irq_clear_bit3", 32'(irq_o), 32'h0);
    wr(3'd2, 32'h2, 4'hF);

    // W1C lands on the same edge that sets bit1
    gpio_i = 4'h2;
    repeat (LAT) @(negedge clk);
    wr(3'd4, 32'h2, 4'hF);
    chk("set_wins_irq", 32'(irq_o), 32'h1);
    rd(3'd4, 32'h2, "set_wins_stat");
    wr(3'd4, 32'h2, 4'hF);
    rd(3'd4, 32'h0, "stat_cleared");

    // 5-cycle pulse on bit0
    gpio_i = 4'h3;
    repeat (5) @(negedge clk);
    gpio_i = 4'h2;
    repeat (LAT + 6) @(negedge clk);
    rd(3'd1, 32'h2, "glitch_din");
    rd(3'd4, GLITCH_STAT, "glitch_stat");
    wr(3'd4, 32'hF, 4'hF);

    // unmapped address
    rd(3'd5, 32'h0, "unmapped_read");
    wr(3'd5, 32'hFFFF_FFFF, 4'hF);
    rd(3'd0, 32'hC, "unmapped_wr_dout");
    rd(3'd2, 32'h2, "unmapped_wr_en");
    rd(3'd3, 32'h2, "unmapped_wr_pol");

    // reset during an acked write with strobe still held
    gpio_i = 4'h0;
    repeat (LAT + 3) @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 3'd0; wb_dat_i = 32'h3; wb_sel_i = 4'hF;
    @(posedge clk); #1;
    chk("mid_ack_before_rst", 32'(wb_ack_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_ack_async", 32'(wb_ack_o), 32'h0);
    chk("rst_gpio_async", 32'(gpio_o), 32'h5);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_ack", 32'(wb_ack_o), 32'h0);
    chk("rst_held_gpio", 32'(gpio_o), 32'h5);
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rst = 1'b0;
    rd(3'd0, 32'h5, "post_rst_dout");
    rd(3'd2, 32'h0, "post_rst_en");
    rd(3'd3, 32'h0, "post_rst_pol");
    rd(3'd4, 32'h0, "post_rst_stat");
    chk("post_rst_irq", 32'(irq_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
